// File: rtl/fifo_burst_reader_if.sv
// Bundle of the burst reader's control, FIFO read-port and output-stream signals.
// The master modport is the reader itself; the slave modport is its environment.
interface fifo_burst_reader_if #(
  parameter int DATAWIDTH = 32,
  parameter int LENWIDTH  = 16
);
  logic                 start;
  logic [LENWIDTH-1:0]  len;
  logic                 busy;
  logic                 done;
  logic                 fifo_cs;
  logic                 fifo_ren;
  logic [DATAWIDTH-1:0] fifo_dout;
  logic                 fifo_empty;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATAWIDTH-1:0] m_data;
  logic                 m_last;
  logic [LENWIDTH-1:0]  words_sent;

  modport master (
    input  start, len, fifo_dout, fifo_empty, m_ready,
    output busy, done, fifo_cs, fifo_ren, m_valid, m_data, m_last, words_sent
  );

  modport slave (
    output start, len, fifo_dout, fifo_empty, m_ready,
    input  busy, done, fifo_cs, fifo_ren, m_valid, m_data, m_last, words_sent
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst read engine for syncfifo: drains a programmed number of words from the
// FIFO read port into a valid/ready stream. A small circular prefetch buffer
// hides the FIFO's one-cycle read latency; the read enable depends only on
// registered state and the FIFO empty flag, never on m_ready.
module fifo_burst_reader #(
  parameter int DATAWIDTH = 32,
  parameter int LENWIDTH  = 16,
  parameter int BUFDEPTH  = 3
) (
  input logic                 clk,
  input logic                 rst,
  fifo_burst_reader_if.master bus
);

  localparam int PTRW = (BUFDEPTH > 1) ? $clog2(BUFDEPTH) : 1;
  localparam int CNTW = $clog2(BUFDEPTH + 1);
  localparam logic [CNTW:0] DEPTH_V = BUFDEPTH[CNTW:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state;
  logic [LENWIDTH-1:0]  len_q;
  logic [LENWIDTH-1:0]  issued;
  logic [LENWIDTH-1:0]  sent;
  logic                 inflight;
  logic [DATAWIDTH-1:0] buf_mem [BUFDEPTH];
  logic [PTRW-1:0]      head;
  logic [PTRW-1:0]      tail;
  logic [CNTW-1:0]      count;

  logic                 running;
  logic                 ren;
  logic                 push;
  logic                 pop;
  logic                 valid;
  logic                 last;
  logic [CNTW:0]        reserved;

  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == PTRW'(BUFDEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // Buffered words plus the word still coming back from the FIFO bound new reads.
  assign reserved = {1'b0, count} + {{CNTW{1'b0}}, inflight};
  assign running  = (state == S_RUN);
  assign ren      = running && !bus.fifo_empty && (issued < len_q) && (reserved < DEPTH_V);
  assign push     = inflight;
  assign valid    = (count != '0);
  assign pop      = valid && bus.m_ready;
  assign last     = valid && (sent == len_q - LENWIDTH'(1));

  assign bus.busy       = running;
  assign bus.done       = (state == S_DONE);
  assign bus.fifo_cs    = running;
  assign bus.fifo_ren   = ren;
  assign bus.m_valid    = valid;
  assign bus.m_data     = buf_mem[head];
  assign bus.m_last     = last;
  assign bus.words_sent = sent;

  // Burst sequencing, read issue tracking and handshake counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      issued   <= '0;
      sent     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= ren;
      if (ren) issued <= issued + LENWIDTH'(1);
      if (pop) sent <= sent + LENWIDTH'(1);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            len_q  <= bus.len;
            issued <= '0;
            sent   <= '0;
            state  <= (bus.len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (pop && last) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Prefetch buffer: FIFO data lands here the cycle after its read, head feeds the stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < BUFDEPTH; i++) buf_mem[i] <= '0;
    end else begin
      if (push) begin
        buf_mem[tail] <= bus.fifo_dout;
        tail          <= next_ptr(tail);
      end
      if (pop) head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
Read-side engine for the team's synchronous FIFO (syncfifo). On a start pulse it drains exactly LEN words from the FIFO read port and presents them on a valid/ready output stream, marking the final word. A small internal prefetch buffer absorbs the FIFO's one-cycle read latency, so the stream sustains one word per cycle with no combinational path from m_ready to fifo_ren. The block sits between the FIFO and any downstream consumer (DMA, serializer).

Parameters:
DATAWIDTH, 32, FIFO word and stream data width
LENWIDTH, 16, width of burst length and counters
BUFDEPTH, 3, prefetch buffer entries (minimum 3; 3 required for full throughput)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  burst start pulse, accepted only when busy=0
len  in  LENWIDTH  burst length in words, sampled with start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final word handshake
fifo_cs  out  1  FIFO chip select; equals busy
fifo_ren  out  1  FIFO read enable
fifo_dout  in  DATAWIDTH  FIFO read data, valid the cycle after a read edge
fifo_empty  in  1  FIFO empty flag
m_valid  out  1  stream data valid
m_ready  in  1  stream consumer ready
m_data  out  DATAWIDTH  stream data (buffer head)
m_last  out  1  high with the final word of the burst
words_sent  out  LENWIDTH  words handshaken in the current or last burst

Behaviour:
- Reset: state IDLE; busy=0, done=0, fifo_cs=0, fifo_ren=0, m_valid=0, m_last=0, m_data=0, words_sent=0. Buffer, issued count, and in-flight flag cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 and len!=0 -> latch len, clear issued count and words_sent, go to RUN. start=1 and len=0 -> go to DONE, no FIFO reads.
- RUN: fifo_ren = !fifo_empty && issued<len && (occupancy + inflight) < BUFDEPTH, decoded from registered state only.
- Each asserted fifo_ren increments issued. The inflight flag is set for one cycle. The next edge pushes fifo_dout into the buffer.
- m_valid = buffer non-empty. m_data = head entry.
- m_last = m_valid && (words_sent == len_latched-1).
- Handshake: m_valid && m_ready pops the head and increments words_sent.
- m_data stays stable while m_valid=1 and m_ready=0.
- Push and pop may occur on the same edge; occupancy stays unchanged.
- Handshake of the m_last word -> go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then go to IDLE. words_sent holds until the next accepted start.
- Latency: with start sampled at edge E0 and the FIFO non-empty, fifo_ren is high in cycle E0..E1, and m_valid first rises after E2.
- Throughput: with m_ready=1 and the FIFO non-empty, one word per cycle is sustained.
- No over-read: issued never exceeds len. fifo_ren is never high while fifo_empty=1 or outside RUN.
- FIFO empty mid-burst: reads stall and the buffer drains. Reading resumes on the first cycle fifo_empty=0. No word is lost or duplicated.
- start while busy=1: ignored, with no effect on len or counters.
- Reset mid-burst: immediate return to IDLE; buffered and in-flight words are discarded. done is not pulsed.
- Counters are LENWIDTH bits. len up to 2^LENWIDTH-1 is supported without wrap.

Test Plan:
- Basic: write 1..5 into FIFO, start with len=5, m_ready=1. Required: m_data 1,2,3,4,5 on consecutive cycles; m_last only on 5; done one cycle after; words_sent=5; exactly 5 fifo_ren pulses.
- Backpressure: 8 words in FIFO, len=8, m_ready toggling 1,0,0,1,... Required: in-order delivery, m_data stable during stalls, occupancy+inflight never >3, no fifo_ren beyond 8.
- Underflow stall: FIFO holds 2 words, len=4, 2 more written 10 cycles later. Required: words 1,2 delivered; m_valid=0 and fifo_ren=0 while empty; words 3,4 follow; done pulses once.
- Zero length and busy start: start with len=0 -> done the next cycle, no fifo_ren. Start with len=3 while busy -> ignored; the original burst length is honoured.
- Partial drain: 6 words in FIFO, len=4. Required: 4 reads, 2 words remain (fifo_empty=0 after done); m_last on the 4th word.
- Reset mid-burst: len=6, rst=1 after 3 handshakes. Required: next cycle all outputs at reset values, no done pulse. A new start with len=2 delivers the next two FIFO words.
